// File: rtl/game_countdown_timer_if.sv
// Bus between the level countdown timer and its users: strobe and control
// inputs from the tick generator / game FSM, display and status outputs
// back to the FSM and HUD.
interface game_countdown_timer_if;
  logic        tick_1ms;
  logic        load;
  logic [11:0] load_val;
  logic        start;
  logic        pause;
  logic [11:0] time_bcd;
  logic        running;
  logic        hurry;
  logic        time_up;
  logic        expired;

  // Controller side: drives strobes and controls, observes the timer.
  modport master (
    output tick_1ms, load, load_val, start, pause,
    input  time_bcd, running, hurry, time_up, expired
  );

  // Timer side.
  modport slave (
    input  tick_1ms, load, load_val, start, pause,
    output time_bcd, running, hurry, time_up, expired
  );
endinterface

// File: rtl/game_countdown_timer.sv
// Level countdown timer: counts tick_1ms strobes into seconds and walks a
// three-digit BCD remaining-time value down to 000, raising a hurry flag
// below 100 s and a single-cycle time_up event on expiry.
//
// Per-cycle priority is rst > load > start/pause > tick. ms_cnt survives
// PAUSE so a second is only ever disturbed by the tick discarded on the
// pause or resume cycle itself.
module game_countdown_timer #(
  parameter int          MS_PER_SEC = 1000,   // legal range 2..1023
  parameter logic [11:0] START_TIME = 12'h400
) (
  input  logic                  mclk,
  input  logic                  rst,
  game_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Last ms_cnt value of a second; the tick that arrives here rolls a second.
  localparam logic [9:0] MS_LAST = 10'(MS_PER_SEC - 1);

  state_t      state_r;
  logic [11:0] time_bcd_r;
  logic [9:0]  ms_cnt_r;
  logic        running_r;
  logic        time_up_r;
  logic        expired_r;
  logic        hurry_s;
  logic [11:0] time_dec_s;

  // Force any non-decimal nibble to 9 so the display never shows A..F.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      return 4'd9;
    end else begin
      return d;
    end
  endfunction

  function automatic logic [11:0] clamp_bcd(input logic [11:0] v);
    return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
  endfunction

  // One-second BCD decrement with borrow; saturates at 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
    hun = v[11:8];
    ten = v[7:4];
    one = v[3:0];
    if (v == 12'h000) begin
      return 12'h000;
    end else if (one != 4'd0) begin
      one = one - 4'd1;
    end else begin
      one = 4'd9;
      if (ten != 4'd0) begin
        ten = ten - 4'd1;
      end else begin
        ten = 4'd9;
        hun = hun - 4'd1;
      end
    end
    return {hun, ten, one};
  endfunction

  // Next displayed value when the current second completes.
  always_comb begin
    time_dec_s = bcd_dec(time_bcd_r);
  end

  // Hurry decodes registered state only, so it adds no latency.
  always_comb begin
    hurry_s = 1'b0;
    if ((time_bcd_r[11:8] == 4'd0) && (state_r != ST_IDLE)) begin
      hurry_s = 1'b1;
    end else begin
      hurry_s = 1'b0;
    end
  end

  // Timer FSM with ms/second counting and registered status outputs.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      time_bcd_r <= START_TIME;
      ms_cnt_r   <= 10'd0;
      running_r  <= 1'b0;
      time_up_r  <= 1'b0;
      expired_r  <= 1'b0;
    end else if (bus.load) begin
      state_r    <= ST_IDLE;
      time_bcd_r <= clamp_bcd(bus.load_val);
      ms_cnt_r   <= 10'd0;
      running_r  <= 1'b0;
      time_up_r  <= 1'b0;
      expired_r  <= 1'b0;
    end else begin
      time_up_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (time_bcd_r == 12'h000) begin
              state_r   <= ST_EXPIRED;
              time_up_r <= 1'b1;
              expired_r <= 1'b1;
              running_r <= 1'b0;
            end else if (bus.pause) begin
              state_r   <= ST_PAUSE;
              running_r <= 1'b0;
            end else begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end
          end else begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end
        end

        ST_RUN: begin
          if (bus.pause) begin
            // Tick on the pausing cycle is intentionally dropped.
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else if (bus.tick_1ms) begin
            if (ms_cnt_r < MS_LAST) begin
              ms_cnt_r <= ms_cnt_r + 10'd1;
            end else begin
              ms_cnt_r   <= 10'd0;
              time_bcd_r <= time_dec_s;
              if (time_dec_s == 12'h000) begin
                state_r   <= ST_EXPIRED;
                time_up_r <= 1'b1;
                expired_r <= 1'b1;
                running_r <= 1'b0;
              end else begin
                state_r   <= ST_RUN;
              end
            end
          end else begin
            state_r <= ST_RUN;
          end
        end

        ST_PAUSE: begin
          if (!bus.pause) begin
            // Tick on the resume cycle is intentionally dropped.
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end
        end

        ST_EXPIRED: begin
          // Only load or rst leaves here; start and ticks are ignored.
          state_r   <= ST_EXPIRED;
          expired_r <= 1'b1;
          running_r <= 1'b0;
        end

        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
          expired_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_bcd = time_bcd_r;
  assign bus.running  = running_r;
  assign bus.hurry    = hurry_s;
  assign bus.time_up  = time_up_r;
  assign bus.expired  = expired_r;

  game_countdown_timer_chk u_chk (
    .mclk     (mclk),
    .rst      (rst),
    .time_bcd (time_bcd_r),
    .running  (running_r),
    .time_up  (time_up_r),
    .expired  (expired_r)
  );

endmodule

// Invariant checks on the timer's registered outputs.
module game_countdown_timer_chk (
  input logic        mclk,
  input logic        rst,
  input logic [11:0] time_bcd,
  input logic        running,
  input logic        time_up,
  input logic        expired
);

  // The expiry event always coincides with the expired level.
  a_time_up_expired : assert property (@(posedge mclk) disable iff (rst)
    time_up |-> expired);

  // Counting and expiry are mutually exclusive.
  a_run_not_expired : assert property (@(posedge mclk) disable iff (rst)
    running |-> !expired);

  // The expiry event lasts exactly one cycle.
  a_time_up_single : assert property (@(posedge mclk) disable iff (rst)
    time_up |=> !time_up);

  // Displayed digits stay decimal.
  a_bcd_digits : assert property (@(posedge mclk) disable iff (rst)
    (time_bcd[11:8] <= 4'd9) && (time_bcd[7:4] <= 4'd9) && (time_bcd[3:0] <= 4'd9));

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with MS_PER_SEC = 4 and ticks on
// every third cycle. Expected output vectors {time_bcd, running, hurry,
// time_up, expired} are queued when stimulus is driven and compared once
// the edge has been taken.
module tb_game_countdown_timer;

  logic mclk = 1'b0;
  logic rst;

  game_countdown_timer_if bus();

  game_countdown_timer #(
    .MS_PER_SEC (4),
    .START_TIME (12'h400)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  function automatic logic [15:0] v(input logic [11:0] b, input logic r, input logic h,
                                    input logic u, input logic x);
    return {b, r, h, u, x};
  endfunction

  task automatic push(input string t, input logic [15:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk();
    logic [15:0] obs;
    logic [15:0] e;
    string       t;
    obs = {bus.time_bcd, bus.running, bus.hurry, bus.time_up, bus.expired};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h, nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", t, obs, e);
      end
    end
  endtask

  // One clock: drive at negedge, take the posedge, return at the next negedge.
  task automatic step(input logic t, input logic ld, input logic st, input logic [11:0] lv);
    bus.tick_1ms = t;
    bus.load     = ld;
    bus.start    = st;
    bus.load_val = lv;
    @(posedge mclk);
    @(negedge mclk);
    bus.tick_1ms = 1'b0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic cyc(input logic t, input logic ld, input logic st, input logic [11:0] lv,
                     input string tag, input logic [15:0] e);
    push(tag, e);
    step(t, ld, st, lv);
    chk();
  endtask

  // n ticks, each preceded by two idle cycles; checks after the last tick.
  task automatic ticks(input int n, input string tag, input logic [15:0] e);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b0, 1'b0, 12'h000);
      if (i == n - 1) push(tag, e);
      step(1'b1, 1'b0, 1'b0, 12'h000);
    end
    chk();
  endtask

  initial begin
    rst          = 1'b1;
    bus.tick_1ms = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 12'h000;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    @(negedge mclk);

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "reset", v(12'h400, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // 003 counts out to expiry
    cyc(1'b0, 1'b1, 1'b0, 12'h003, "load_003", v(12'h003, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_003", v(12'h003, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(3, "tick3_no_dec", v(12'h003, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(1, "tick4_002", v(12'h002, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(4, "tick8_001", v(12'h001, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(3, "tick11_001", v(12'h001, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(1, "tick12_expire", v(12'h000, 1'b0, 1'b1, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "time_up_single", v(12'h000, 1'b0, 1'b1, 1'b0, 1'b1));
    ticks(4, "expired_ticks", v(12'h000, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "expired_start", v(12'h000, 1'b0, 1'b1, 1'b0, 1'b1));

    // 100 -> 099 borrow and hurry
    cyc(1'b0, 1'b1, 1'b0, 12'h100, "load_100", v(12'h100, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_100", v(12'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    ticks(4, "borrow_099", v(12'h099, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 12'h100, "reload_100", v(12'h100, 1'b0, 1'b0, 1'b0, 1'b0));

    // Pause preserves ms_cnt
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_pause_test", v(12'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    ticks(2, "pre_pause", v(12'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.pause = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "pause_enter", v(12'h100, 1'b0, 1'b0, 1'b0, 1'b0));
    ticks(10, "paused_ticks", v(12'h100, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.pause = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "resume", v(12'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    ticks(1, "post_resume_t3", v(12'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    ticks(1, "post_resume_t4", v(12'h099, 1'b1, 1'b1, 1'b0, 1'b0));

    // Ticks on the pause and resume cycles are discarded
    bus.pause = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 12'h000, "pause_tick_drop", v(12'h099, 1'b0, 1'b1, 1'b0, 1'b0));
    bus.pause = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 12'h000, "resume_tick_drop", v(12'h099, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(3, "drop_t3", v(12'h099, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(1, "drop_t4", v(12'h098, 1'b1, 1'b1, 1'b0, 1'b0));

    // Digit clamping, tens borrow and zero start
    cyc(1'b0, 1'b1, 1'b0, 12'h9A9, "clamp_9A9", v(12'h999, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 12'hAF5, "clamp_AF5", v(12'h995, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 12'h010, "load_010", v(12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_010", v(12'h010, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(4, "borrow_009", v(12'h009, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 12'h000, "load_000", v(12'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_000", v(12'h000, 1'b0, 1'b1, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "start_000_after", v(12'h000, 1'b0, 1'b1, 1'b0, 1'b1));

    // Start with pause held goes straight to PAUSE
    cyc(1'b0, 1'b1, 1'b0, 12'h005, "load_005", v(12'h005, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.pause = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_paused", v(12'h005, 1'b0, 1'b1, 1'b0, 1'b0));
    bus.pause = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "start_paused_go", v(12'h005, 1'b1, 1'b1, 1'b0, 1'b0));

    // load + start + tick together: load wins and ms_cnt clears
    ticks(2, "pre_load_ms2", v(12'h005, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc(1'b1, 1'b1, 1'b1, 12'h050, "load_start_tick", v(12'h050, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_050", v(12'h050, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(3, "ms_clear_t3", v(12'h050, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(1, "ms_clear_t4", v(12'h049, 1'b1, 1'b1, 1'b0, 1'b0));

    // rst mid-run
    cyc(1'b0, 1'b1, 1'b0, 12'h057, "load_057", v(12'h057, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_057", v(12'h057, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(2, "pre_rst", v(12'h057, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 12'h000, "rst_mid_run", v(12'h400, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 12'h000, "start_400", v(12'h400, 1'b1, 1'b0, 1'b0, 1'b0));
    ticks(3, "rst_ms_t3", v(12'h400, 1'b1, 1'b0, 1'b0, 1'b0));
    ticks(1, "rst_ms_t4", v(12'h399, 1'b1, 1'b0, 1'b0, 1'b0));

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Consumes the 1 ms strobe from the on-board tick generator and maintains the level's remaining-time counter: three BCD digits of seconds, counted down from a loadable value, default 400. Sits between the tick generator and the game FSM and HUD. It provides the display digits, a hurry-up flag, and a single-cycle time-up event that ends the level.

## Interface
- MS_PER_SEC, default 1000: tick_1ms strobes per displayed second; legal range 2..1023.
- START_TIME, default 12'h400: BCD value taken on reset.
- mclk  in  1: system clock; all logic on its rising edge.
- rst  in  1: synchronous, active-high reset.
- tick_1ms  in  1: one-cycle strobe from the tick generator; every cycle it is high counts as one tick.
- load  in  1: load load_val into the counter and return to IDLE.
- load_val  in  12: BCD seconds {hundreds, tens, ones}.
- start  in  1: begin or resume counting from IDLE.
- pause  in  1: level; while high in RUN, counting is frozen.
- time_bcd  out  12: remaining seconds, BCD, registered.
- running  out  1: high in RUN only.
- hurry  out  1: high when the hundreds digit is 0 and the state is not IDLE.
- time_up  out  1: one-cycle pulse on entry to EXPIRED.
- expired  out  1: high in EXPIRED.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Internal ms_cnt is 10 bits and counts tick_1ms strobes within the current second.
- Per-cycle priority: rst > load > start/pause > tick.
- Reset:
  - time_bcd = START_TIME, ms_cnt = 0, state IDLE.
  - running, hurry, time_up and expired are all 0.
- load, any state:
  - time_bcd is loaded from load_val; any digit > 9 is clamped to 9.
  - ms_cnt = 0, state IDLE, time_up = 0. A same-cycle start or tick is ignored.
- IDLE + start:
  - If time_bcd == 000: go to EXPIRED with a time_up pulse.
  - Otherwise: go to RUN, or to PAUSE if pause is high in the same cycle. ms_cnt is kept.
- RUN + pause high: go to PAUSE. A same-cycle tick is discarded.
- PAUSE + pause low: go to RUN. A same-cycle tick is discarded.
- start in RUN, PAUSE or EXPIRED: ignored. Leaving EXPIRED requires load or rst.
- RUN + tick, not pausing:
  - If ms_cnt < MS_PER_SEC-1: ms_cnt += 1.
  - Otherwise: ms_cnt = 0 and time_bcd is decremented by one in BCD with borrow (e.g. 100 -> 099, 010 -> 009).
  - If the decrement produces 000: state EXPIRED, time_up pulse, time_bcd holds 000.
- time_bcd never wraps below 000. A tick in EXPIRED or IDLE changes nothing.
- hurry is combinational from the registered state and time_bcd[11:8], so it has no extra latency.

## Timing
- Every output is registered except hurry, which decodes registered values only.
- Tick-to-display latency: time_bcd changes on the first mclk edge after the cycle in which the final tick of a second was sampled.
- time_up is high for exactly the one cycle in which expired first reads 1. It never repeats until a new load/start sequence.
- A start in cycle N shows running = 1 in cycle N+1. A tick sampled in cycle N+1 counts.
- Pause and resume are glitch-free: ms_cnt is preserved across PAUSE, so a second is never shortened or lengthened except by ticks discarded on the pause/resume cycle itself.
- rst mid-count restores START_TIME on the next edge regardless of state.

## Test plan
(All scenarios use MS_PER_SEC = 4 and tick_1ms pulsed every 3rd cycle unless stated.)
- Reset, then load 12'h003 and start.
  - After 12 ticks: time_bcd reads 002, 001, 000.
  - time_up is a single pulse together with expired rising; running falls; further ticks leave 000.
- load 12'h100, start, 4 ticks.
  - time_bcd = 099; hurry rises in the same cycle.
  - load 12'h100 again: hurry = 0 and state IDLE.
- start, 2 ticks, hold pause for 10 ticks, release, 2 ticks.
  - time_bcd decrements exactly once, after the 4th counted tick; running is low throughout the pause.
- load 12'h9A9 -> time_bcd = 999. load 12'h000 then start -> time_up pulses the next cycle with no ticks.
- Same cycle load = 1, start = 1, tick = 1 -> IDLE with load value, ms_cnt = 0.
- Assert rst during RUN at time_bcd = 057 -> time_bcd = 400, all flags 0, state IDLE.
